key_flag_gen: RTL and testbench

- Upstream conditioning stage for the RAM write/read controller.
- Takes two raw, active-low push-button inputs (write key, read key).
- Synchronises and debounces each key.
- Emits the single-cycle wr_flag / rd_flag pulses that the RAM controller consumes to start a 256-address write sweep or a timed read sweep.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce.sv | 115 +++++++++++
 rtl/key_flag_gen.sv | 68 ++++++
 tb/tb_key_flag_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants for the key conditioning slice: per-key FSM state encoding
// and default debounce / auto-repeat periods (50 MHz system clock).
package key_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE      = 2'd0;
  localparam key_state_t ST_PRESS_DEB = 2'd1;
  localparam key_state_t ST_HELD      = 2'd2;
  localparam key_state_t ST_REL_DEB   = 2'd3;

  localparam logic [19:0] CNT_MAX_DEF    = 20'd999_999;
  localparam logic [24:0] REPEAT_MAX_DEF = 25'd24_999_999;

endpackage

// File: rtl/key_debounce.sv
// One active-low push button: 2-flop synchroniser, press/release debounce FSM,
// optional auto-repeat while held (KEY_AUTO_REPEAT_EN).
module key_debounce
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = CNT_MAX_DEF
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter logic [24:0] REPEAT_MAX = REPEAT_MAX_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_key_n,
  output logic o_confirm,
  output logic o_not_idle
);

  logic       r_sync1;
  logic       r_sync2;
  key_state_t r_state;
  logic [19:0] r_cnt;
  logic       r_confirm;
  logic       w_key_s;
  logic       w_rep_fire;

  // NOTE: the synchroniser presets to 1 (released) so reset release never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_s = r_sync2;

`ifdef KEY_AUTO_REPEAT_EN
  logic [24:0] r_rep_cnt;
  logic        r_held_q;

  // Repeat period is timed from the first full cycle spent in HELD.
  assign w_rep_fire = (r_state == ST_HELD) && !w_key_s && r_held_q &&
                      (r_rep_cnt == REPEAT_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rep_cnt <= '0;
      r_held_q  <= 1'b0;
    end else begin
      r_held_q <= (r_state == ST_HELD);
      if ((r_state != ST_HELD) || w_key_s || !r_held_q || w_rep_fire)
        r_rep_cnt <= '0;
      else
        r_rep_cnt <= r_rep_cnt + 25'd1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_confirm <= 1'b0;
    end else begin
      r_confirm <= w_rep_fire;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_key_s) r_state <= ST_PRESS_DEB;
        end
        ST_PRESS_DEB: begin
          if (w_key_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= ST_HELD;
            r_cnt     <= '0;
            r_confirm <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        ST_HELD: begin
          r_cnt <= '0;
          if (w_key_s) r_state <= ST_REL_DEB;
        end
        ST_REL_DEB: begin
          if (!w_key_s) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_confirm  = r_confirm;
  assign o_not_idle = (r_state != ST_IDLE);

endmodule

// File: rtl/key_flag_gen.sv
// Write/read key conditioning for the RAM controller: two debounced keys,
// write-priority arbitration, registered one-cycle flags. Option: KEY_AUTO_REPEAT_EN.
module key_flag_gen
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = CNT_MAX_DEF,
  parameter logic [24:0] REPEAT_MAX = REPEAT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_wr,
  input  logic key_rd,
  output logic wr_flag,
  output logic rd_flag,
  output logic key_busy
);

  logic w_wr_confirm;
  logic w_rd_confirm;
  logic w_wr_not_idle;
  logic w_rd_not_idle;

  if (REPEAT_MAX == '0) begin : g_bad_repeat
    $error("key_flag_gen: REPEAT_MAX must be nonzero");
  end

  key_debounce #(
    .CNT_MAX    (CNT_MAX)
`ifdef KEY_AUTO_REPEAT_EN
    ,
    .REPEAT_MAX (REPEAT_MAX)
`endif
  ) u_wr_key (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_key_n    (key_wr),
    .o_confirm  (w_wr_confirm),
    .o_not_idle (w_wr_not_idle)
  );

  key_debounce #(
    .CNT_MAX    (CNT_MAX)
`ifdef KEY_AUTO_REPEAT_EN
    ,
    .REPEAT_MAX (REPEAT_MAX)
`endif
  ) u_rd_key (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_key_n    (key_rd),
    .o_confirm  (w_rd_confirm),
    .o_not_idle (w_rd_not_idle)
  );

  // Write wins a same-cycle tie; the losing read confirm is dropped, not deferred.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_flag  <= 1'b0;
      rd_flag  <= 1'b0;
      key_busy <= 1'b0;
    end else begin
      wr_flag  <= w_wr_confirm;
      rd_flag  <= w_rd_confirm & ~w_wr_confirm;
      key_busy <= w_wr_not_idle | w_rd_not_idle;
    end
  end

endmodule

// File: tb/tb_key_flag_gen.sv
// Directed bench for key_flag_gen with CNT_MAX=15, REPEAT_MAX=63.
// Cycle k = outputs sampled just after the k-th rising edge following a stimulus change.
module tb_key_flag_gen;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_wr  = 1'b1;
  logic key_rd  = 1'b1;
  logic wr_flag;
  logic rd_flag;
  logic key_busy;

  int n_checks = 0;
  int n_errors = 0;

  int edge_idx   = -1;
  int base       = 0;
  int busy_first = -1;
  int wr_pos[$];
  int rd_pos[$];
  int exp_q[$];

  key_flag_gen #(
    .CNT_MAX    (20'd15),
    .REPEAT_MAX (25'd63)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_wr   (key_wr),
    .key_rd   (key_rd),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .key_busy (key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Records pulse positions relative to the current test's cycle 0.
  always @(posedge sys_clk) begin
    #1;
    edge_idx++;
    if (wr_flag) wr_pos.push_back(edge_idx - base);
    if (rd_flag) rd_pos.push_back(edge_idx - base);
    if (key_busy && busy_first < 0) busy_first = edge_idx - base;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input int got_q[$], input int want_q[$]);
    check({tag, "_count"}, got_q.size(), want_q.size());
    foreach (want_q[i]) begin
      if (i < got_q.size())
        check($sformatf("%s_pos%0d", tag, i), got_q[i], want_q[i]);
      else
        check($sformatf("%s_pos%0d", tag, i), -1, want_q[i]);
    end
  endtask

  // Call on a falling edge: the next rising edge becomes cycle 0.
  task automatic start_test();
    base       = edge_idx + 1;
    busy_first = -1;
    wr_pos.delete();
    rd_pos.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_wr_flag", int'(wr_flag), 0);
    check("rst_rd_flag", int'(rd_flag), 0);
    check("rst_key_busy", int'(key_busy), 0);
    sys_rst = 1'b0;
    wait_cyc(5);

    // Clean write press: pulse at 19, busy from 3
    start_test();
    key_wr = 1'b0;
    wait_cyc(40);
    exp_q = '{19};
    check_pulses("clean_wr", wr_pos, exp_q);
    check("clean_rd_count", rd_pos.size(), 0);
    check("clean_busy_first", busy_first, 3);
    key_wr = 1'b1;
    wait_cyc(40);
    check("clean_busy_released", int'(key_busy), 0);

    // Bouncing read key: toggles every 5 cycles, last fall at 60
    start_test();
    for (int t = 0; t < 60; t += 5) begin
      key_rd = ((t / 5) % 2 == 1);
      wait_cyc(5);
    end
    key_rd = 1'b0;
    wait_cyc(60);
    exp_q = '{79};
    check_pulses("bounce_rd", rd_pos, exp_q);
    check("bounce_wr_count", wr_pos.size(), 0);
    key_rd = 1'b1;
    wait_cyc(40);

    // Press, long release, re-press, then a short release glitch while held
    start_test();
    key_wr = 1'b0;
    wait_cyc(40);
    key_wr = 1'b1;
    wait_cyc(40);
    key_wr = 1'b0;
    wait_cyc(40);
    key_wr = 1'b1;
    wait_cyc(8);
    key_wr = 1'b0;
    wait_cyc(32);
    key_wr = 1'b1;
    wait_cyc(40);
    exp_q = '{19, 99};
    check_pulses("repress_wr", wr_pos, exp_q);

    // Simultaneous press: write wins, read consumed
    start_test();
    key_wr = 1'b0;
    key_rd = 1'b0;
    wait_cyc(40);
    key_wr = 1'b1;
    key_rd = 1'b1;
    wait_cyc(40);
    exp_q = '{19};
    check_pulses("simul_wr", wr_pos, exp_q);
    check("simul_rd_count", rd_pos.size(), 0);

    // Reset in the middle of PRESS_DEB, key kept low through reset
    start_test();
    key_wr = 1'b0;
    wait_cyc(12);
    sys_rst = 1'b1;
    #1;
    check("midrst_wr_flag", int'(wr_flag), 0);
    check("midrst_rd_flag", int'(rd_flag), 0);
    check("midrst_key_busy", int'(key_busy), 0);
    wait_cyc(2);
    sys_rst = 1'b0;
    start_test();
    wait_cyc(40);
    exp_q = '{19};
    check_pulses("midrst_wr", wr_pos, exp_q);
    key_wr = 1'b1;
    wait_cyc(40);

    // Long read hold: auto-repeat when compiled in, otherwise one pulse
    start_test();
    key_rd = 1'b0;
    wait_cyc(200);
    key_rd = 1'b1;
    wait_cyc(40);
`ifdef KEY_AUTO_REPEAT_EN
    exp_q = '{19, 84, 148};
`else
    exp_q = '{19};
`endif
    check_pulses("hold_rd", rd_pos, exp_q);
    check("hold_wr_count", wr_pos.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
